// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: deserialises PS/2 device-to-host frames into a held scan code
// with a one-cycle make strobe; E0/F0 prefixes and keyboard error bytes are filtered here.
module ps2_scan_receiver #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit DROP_EXTENDED  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_signal_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       set_signal,
    output logic       key_held,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [1:0]    clk_sync, data_sync;
    logic          prev;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic [TW-1:0] t_cnt;
    logic          ext_pend, brk_pend;
    logic          fall, din, frame_ok, drop_ext;

    assign fall     = prev & ~clk_sync[1];
    assign din      = data_sync[1];
    assign frame_ok = (^shreg ^ parity) & din;
    assign drop_ext = ext_pend & DROP_EXTENDED;

    // Sync flops reset to line-idle so reset release never looks like a falling edge
    always_ff @(posedge clk or negedge reset_signal_n) begin
        if (!reset_signal_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            prev      <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            prev      <= clk_sync[1];
        end
    end

    always_ff @(posedge clk or negedge reset_signal_n) begin
        if (!reset_signal_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            t_cnt      <= '0;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            code       <= '0;
            key_held   <= 1'b0;
            set_signal <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            set_signal <= 1'b0;
            frame_err  <= 1'b0;
            if (fall)
                t_cnt <= '0;
            else if (state == SHIFT && t_cnt != T_MAX)
                t_cnt <= t_cnt + 1'b1;
            if (state == IDLE) begin
                if (fall && !din) begin
                    state   <= SHIFT;
                    bit_cnt <= 4'd1;
                end
            end else if (fall) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt <= 4'd8)
                    shreg <= {din, shreg[7:1]};
                else if (bit_cnt == 4'd9)
                    parity <= din;
                else begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    if (!frame_ok || shreg == 8'h00 || shreg == 8'hFF) begin
                        frame_err <= 1'b1;
                        ext_pend  <= 1'b0;
                        brk_pend  <= 1'b0;
                    end else if (shreg == 8'hE0)
                        ext_pend <= 1'b1;
                    else if (shreg == 8'hF0)
                        brk_pend <= 1'b1;
                    else if (shreg != 8'hAA && shreg != 8'hFA) begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                        if (brk_pend) begin
                            if (key_held && shreg == code && !drop_ext) begin
                                code     <= 8'h00;
                                key_held <= 1'b0;
                            end
                        end else if (!drop_ext && !(key_held && shreg == code)) begin
                            code       <= shreg;
                            key_held   <= 1'b1;
                            set_signal <= 1'b1;
                        end
                    end
                end
            end else if (t_cnt == T_MAX) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: directed frame table, timeout/reset sequences and
// randomized frames checked against a key-state reference model.
module tb_ps2_scan_receiver;
    localparam int TO = 100;
    localparam int H  = 8;

    typedef struct {
        logic [7:0] b;
        logic       bad_par;
        logic [7:0] code;
        logic       held;
        int         sets;
        int         errs;
    } vec_t;

    logic clk = 1'b0, reset_signal_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] code;
    logic set_signal, key_held, frame_err;
    int checks = 0, errors = 0;
    int cyc = 0, n_set = 0, n_err = 0;
    int last_set_cyc = 0, last_err_cyc = 0, fall_cyc = 0;
    logic set_d = 1'b0;
    vec_t tbl[18];
    logic [7:0] m_code;
    logic m_held, m_ext, m_brk;

    ps2_scan_receiver #(.TIMEOUT_CYCLES(TO), .DROP_EXTENDED(1'b1)) dut (
        .clk(clk), .reset_signal_n(reset_signal_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .code(code), .set_signal(set_signal), .key_held(key_held), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (set_signal) begin
            n_set++;
            last_set_cyc = cyc;
            checks++;
            if (set_d || frame_err) begin
                errors++;
                $display("FAIL strobe_shape: set_signal=1 prev_set=%0b frame_err=%0b cycle %0d", set_d, frame_err, cyc);
            end
        end
        if (frame_err) begin
            n_err++;
            last_err_cyc = cyc;
        end
        set_d = set_signal;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (H) @(negedge clk);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bits({~bad_stop, ~^b ^ bad_par, b, 1'b0}, 11);
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_row(input int i);
        int s0, e0;
        s0 = n_set;
        e0 = n_err;
        send_frame(tbl[i].b, tbl[i].bad_par, 1'b0);
        check($sformatf("row%0d code", i), 32'(code), 32'(tbl[i].code));
        check($sformatf("row%0d key_held", i), 32'(key_held), 32'(tbl[i].held));
        check($sformatf("row%0d set_pulses", i), n_set - s0, tbl[i].sets);
        check($sformatf("row%0d err_pulses", i), n_err - e0, tbl[i].errs);
    endtask

    // Reference: what the keyboard trainer should see after one received byte
    task automatic model(input logic [7:0] b, input logic ok, output int es, output int ee);
        es = 0;
        ee = 0;
        if (!ok || b == 8'h00 || b == 8'hFF) begin
            ee = 1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b != 8'hAA && b != 8'hFA) begin
            if (m_brk) begin
                if (m_held && b == m_code && !m_ext) begin
                    m_code = 8'h00;
                    m_held = 1'b0;
                end
            end else if (!m_ext && !(m_held && b == m_code)) begin
                m_code = b;
                m_held = 1'b1;
                es = 1;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    initial begin
        int s0, e0, es, ee, r;
        logic [7:0] b;
        logic bp, bs;
        logic [7:0] pool [10];
        pool = '{8'h1C, 8'h5A, 8'h1B, 8'h75, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h00, 8'hFF};
        tbl[0]  = '{8'h1C, 1'b0, 8'h1C, 1'b1, 1, 0};
        tbl[1]  = '{8'h1C, 1'b0, 8'h1C, 1'b1, 0, 0};
        tbl[2]  = '{8'h1C, 1'b0, 8'h1C, 1'b1, 0, 0};
        tbl[3]  = '{8'hF0, 1'b0, 8'h1C, 1'b1, 0, 0};
        tbl[4]  = '{8'h1C, 1'b0, 8'h00, 1'b0, 0, 0};
        tbl[5]  = '{8'h1C, 1'b0, 8'h1C, 1'b1, 1, 0};
        tbl[6]  = '{8'h5A, 1'b1, 8'h1C, 1'b1, 0, 1};
        tbl[7]  = '{8'h5A, 1'b0, 8'h5A, 1'b1, 1, 0};
        tbl[8]  = '{8'h1B, 1'b0, 8'h1B, 1'b1, 1, 0};
        tbl[9]  = '{8'hF0, 1'b0, 8'h1B, 1'b1, 0, 0};
        tbl[10] = '{8'h1B, 1'b0, 8'h00, 1'b0, 0, 0};
        tbl[11] = '{8'hE0, 1'b0, 8'h00, 1'b0, 0, 0};
        tbl[12] = '{8'h75, 1'b0, 8'h00, 1'b0, 0, 0};
        tbl[13] = '{8'hE0, 1'b0, 8'h00, 1'b0, 0, 0};
        tbl[14] = '{8'hF0, 1'b0, 8'h00, 1'b0, 0, 0};
        tbl[15] = '{8'h75, 1'b0, 8'h00, 1'b0, 0, 0};
        tbl[16] = '{8'hF0, 1'b0, 8'h00, 1'b0, 0, 0};
        tbl[17] = '{8'h1C, 1'b0, 8'h00, 1'b0, 0, 0};

        repeat (4) @(negedge clk);
        check("reset code", 32'(code), 32'h00);
        check("reset key_held", 32'(key_held), 0);
        check("reset set_signal", 32'(set_signal), 0);
        check("reset frame_err", 32'(frame_err), 0);
        reset_signal_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_row(i);
            if (i == 0) check("make latency", 32'(last_set_cyc - fall_cyc), 3);
        end

        s0 = n_set;
        e0 = n_err;
        send_bits({2'b11, 8'h33, 1'b0}, 5);
        ps2_data = 1'b1;
        for (int k = 0; k < TO + 40 && n_err == e0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("timeout err_pulses", n_err - e0, 1);
        check("timeout latency", 32'(last_err_cyc - fall_cyc), TO + 3);
        check("timeout code", 32'(code), 32'h5A);
        check("timeout set_pulses", n_set - s0, 0);

        for (int i = 8; i < 18; i++) run_row(i);

        s0 = n_set;
        send_frame(8'h1C, 1'b0, 1'b0);
        check("pre-reset code", 32'(code), 32'h1C);
        check("pre-reset set_pulses", n_set - s0, 1);
        e0 = n_err;
        send_bits({2'b11, 8'h5A, 1'b0}, 6);
        reset_signal_n = 1'b0;
        #1;
        check("async reset code", 32'(code), 32'h00);
        check("async reset key_held", 32'(key_held), 0);
        repeat (3) @(negedge clk);
        reset_signal_n = 1'b1;
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        check("reset no frame_err", n_err - e0, 0);
        s0 = n_set;
        send_frame(8'h5A, 1'b0, 1'b0);
        check("post-reset code", 32'(code), 32'h5A);
        check("post-reset set_pulses", n_set - s0, 1);
        check("post-reset err_pulses", n_err - e0, 0);

        m_code = 8'h5A;
        m_held = 1'b1;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        for (int n = 0; n < 60; n++) begin
            r  = int'($urandom_range(0, 13));
            b  = (r < 10) ? pool[r] : 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 14) == 0);
            model(b, !bp && !bs, es, ee);
            s0 = n_set;
            e0 = n_err;
            send_frame(b, bp, bs);
            check($sformatf("rand%0d byte %0h code", n, b), 32'(code), 32'(m_code));
            check($sformatf("rand%0d byte %0h key_held", n, b), 32'(key_held), 32'(m_held));
            check($sformatf("rand%0d byte %0h set_pulses", n, b), n_set - s0, es);
            check($sformatf("rand%0d byte %0h err_pulses", n, b), n_err - e0, ee);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
